// File: rtl/wb_result_streamer.sv
// Result FIFO fed over valid/ready, drained byte-serially (LSB first) onto GPIO pads
// through a four-phase strobe/ack handshake, with Wishbone CTRL/STATUS/SENT_COUNT registers.
module wb_result_streamer #(
    parameter int         DEPTH    = 4,
    parameter logic [3:0] ADDR_NIB = 4'h3
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic        res_valid_i,
    input  logic [31:0] res_data_i,
    output logic        res_ready_o,
    output logic [7:0]  pad_dat_o,
    output logic        pad_strb_o,
    input  logic        pad_ack_i,
    output logic [8:0]  pad_oeb_o,
    output logic        irq_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = AW + 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_STROBE  = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    logic        ack_q, ack_d;
    logic [31:0] rdat_q, rdat_d;
    logic        enable_q, enable_d;
    logic        irq_en_q, irq_en_d;
    logic        flush_q, flush_d;
    logic        irq_q;
    logic        ack_meta_q, ack_sync_q;

    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW-1:0] level;
    logic [31:0]   mem_q [DEPTH];
    logic [31:0]   head;
    logic          empty, full, push, pop;

    logic [1:0]  state_q, state_d;
    logic [31:0] shift_q, shift_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        strb_q, strb_d;
    logic [7:0]  pdat_q, pdat_d;
    logic [31:0] sent_q, sent_d;
    logic        busy;

    logic        wb_sel, wb_req, wr_ctrl;
    logic [25:0] word_idx;
    logic [31:0] rd_word;

    // ------------------------------------------------------------ Wishbone
    assign wb_sel   = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:28] == ADDR_NIB);
    assign wb_req   = wb_sel & ~ack_q;
    assign word_idx = wbs_adr_i[27:2];
    assign wr_ctrl  = wb_req & wbs_we_i & wbs_sel_i[0] & (word_idx == 26'd4);

    always_comb begin
        rd_word = '0;
        case (word_idx)
            26'd4:   rd_word = {29'd0, irq_en_q, 1'b0, enable_q};
            26'd5:   rd_word = {24'd0, ack_sync_q, busy, full, empty, 4'(level)};
            26'd6:   rd_word = sent_q;
            default: rd_word = '0;
        endcase
    end

    always_comb begin
        ack_d    = wb_req;
        rdat_d   = (wb_req & ~wbs_we_i) ? rd_word : '0;
        enable_d = enable_q;
        irq_en_d = irq_en_q;
        flush_d  = 1'b0;
        if (wr_ctrl) begin
            enable_d = wbs_dat_i[0];
            flush_d  = wbs_dat_i[1];
            irq_en_d = wbs_dat_i[2];
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ack_q    <= 1'b0;
            rdat_q   <= '0;
            enable_q <= 1'b0;
            irq_en_q <= 1'b0;
            flush_q  <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            ack_q    <= ack_d;
            rdat_q   <= rdat_d;
            enable_q <= enable_d;
            irq_en_q <= irq_en_d;
            flush_q  <= flush_d;
            irq_q    <= irq_en_q & full;
        end
    end

    // ------------------------------------------------------------ FIFO
    assign level = wr_ptr_q - rd_ptr_q;
    assign empty = (level == '0);
    assign full  = (level == PW'(DEPTH));
    assign push  = res_valid_i & ~full;
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    // A pending flush wins over push/pop so the push arriving with it is lost.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush_q) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (push & ~flush_q) mem_q[wr_ptr_q[AW-1:0]] <= res_data_i;
    end

    // ------------------------------------------------------------ pad ack synchroniser
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ack_meta_q <= 1'b0;
            ack_sync_q <= 1'b0;
        end else begin
            ack_meta_q <= pad_ack_i;
            ack_sync_q <= ack_meta_q;
        end
    end

    // ------------------------------------------------------------ serialiser FSM
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        strb_d  = strb_q;
        pdat_d  = pdat_q;
        sent_d  = sent_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable_q & ~empty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    cnt_d   = 2'd0;
                    strb_d  = 1'b1;
                    pdat_d  = head[7:0];
                    state_d = ST_STROBE;
                end
            end
            ST_STROBE: begin
                if (ack_sync_q) begin
                    strb_d  = 1'b0;
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!ack_sync_q) begin
                    if (cnt_q == 2'd3) begin
                        sent_d  = sent_q + 32'd1;
                        state_d = ST_IDLE;
                    end else begin
                        shift_d = shift_q >> 8;
                        cnt_d   = cnt_q + 2'd1;
                        pdat_d  = shift_q[15:8];
                        strb_d  = 1'b1;
                        state_d = ST_STROBE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            strb_q  <= 1'b0;
            pdat_q  <= '0;
            sent_q  <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            strb_q  <= strb_d;
            pdat_q  <= pdat_d;
            sent_q  <= sent_d;
        end
    end

    assign busy = (state_q != ST_IDLE);

    // ------------------------------------------------------------ outputs
    assign wbs_ack_o   = ack_q;
    assign wbs_dat_o   = rdat_q;
    assign res_ready_o = ~full;
    assign pad_dat_o   = pdat_q;
    assign pad_strb_o  = strb_q;
    assign pad_oeb_o   = {9{~(enable_q | busy)}};
    assign irq_o       = irq_q;

    logic unused_bits;
    assign unused_bits = ^{wbs_dat_i[31:3], wbs_sel_i[3:1], wbs_adr_i[1:0]};

endmodule
